ifetch_queue: RTL and testbench
===============================

IFETCH_QUEUE -- requirements
Module: ifetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, the number of fetch-queue entries (power of two, 2..16).
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port init_n, input, 1 bit, the asynchronous active-low reset.
REQ-004 SHALL have port pc_in, input, 32 bits, the current fetch address driven by the next-PC unit.
REQ-005 SHALL have port npc_enable, output, 1 bit, a one-cycle pulse meaning pc_in was accepted and the next-PC unit may advance.
REQ-006 SHALL have port flush, input, 1 bit, a redirect (taken branch, J, Jal or Jr) that discards all queued and in-flight fetches.
REQ-007 SHALL have ports imem_req (output, 1 bit), imem_addr (output, 32 bits), imem_gnt (input, 1 bit), imem_rvalid (input, 1 bit) and imem_rdata (input, 32 bits), forming the instruction-memory request/response pair.
REQ-008 SHALL have ports if_valid (output, 1 bit), if_pc (output, 32 bits), if_instr (output, 32 bits), if_err (output, 1 bit) and id_ready (input, 1 bit), forming the decode-side valid/ready handshake.

Function
REQ-009 SHALL keep at most one memory request outstanding, with states IDLE, WAIT and DROP.
REQ-010 SHALL, in IDLE, assert imem_req with imem_addr equal to pc_in only when (count + 1) <= DEPTH and flush is low.
REQ-011 SHALL, on imem_req and imem_gnt in the same cycle, pulse npc_enable for that cycle, latch pc_in as the tag and go to WAIT.
REQ-012 SHALL, in WAIT, on imem_rvalid, push {tag, imem_rdata, err} into the FIFO and return to IDLE; a new request may issue in the cycle after the response, not the same cycle.
REQ-013 SHALL treat a pc_in with bits [1:0] not equal to 00 as misaligned: no memory request; in the same cycle, push {pc_in, 32'h0 (nop), err=1} and pulse npc_enable, subject to the space check in REQ-010.
REQ-014 SHALL, in DROP, discard the next imem_rvalid and then go to IDLE.
REQ-015 SHALL, on flush: empty the FIFO (count=0) in the same cycle; WAIT goes to DROP; WAIT with imem_rvalid in the same cycle discards the response and goes to IDLE; imem_req is low in that cycle; flush in DROP keeps DROP.
REQ-016 SHALL drive if_valid whenever count > 0, with the head entry on if_pc, if_instr and if_err; a pop occurs on if_valid and id_ready.
REQ-017 SHALL, on a push and a pop in the same cycle, leave count unchanged; the write pointer and read pointer wrap modulo DEPTH.
REQ-018 SHALL give flush priority over push and pop in the same cycle.
REQ-019 SHALL keep the FIFO from overflowing: a push occurs only when a slot was reserved at issue, so count never exceeds DEPTH.
REQ-020 SHALL have a minimum latency of 1 cycle from imem_rvalid to if_valid (registered FIFO output, no bypass).

Reset
REQ-021 SHALL, while init_n is low, asynchronously force: state=IDLE, count=0, both pointers=0, npc_enable=0, imem_req=0, if_valid=0; imem_addr, if_pc, if_instr and if_err read 0.
REQ-022 SHALL, when reset is asserted in WAIT, discard the in-flight response; memory stalls its response until it is reset as well.
REQ-023 SHALL not issue a request in the first cycle after init_n deasserts.

Structure
REQ-024 SHALL place the state encoding (IDLE/WAIT/DROP) and the NOP constant 32'h0 in the shared pipeline package.
REQ-025 SHALL use exactly one sub-module, ifq_fifo (a DEPTH x 65-bit storage array with pointers and count); the FSM, issue and space logic live in ifetch_queue.

Verification
REQ-026 Sequential fetch: pc_in 0,4,8,12; gnt=1 immediately; rvalid 1 cycle after each grant; id_ready=1 -> four npc_enable pulses; if_pc 0,4,8,12 in order with the matching rdata; if_err=0.
REQ-027 Backpressure: id_ready=0 with DEPTH=4 -> exactly 4 entries are pushed, imem_req stays low afterwards, no npc_enable; after id_ready=1, one pop occurs and exactly one new request follows.
REQ-028 Flush in WAIT: request at pc 0x40 granted, flush the next cycle, rvalid with 0xDEADBEEF two cycles later -> the data is never presented; the state sequence is WAIT, DROP, IDLE; the next request is pc_in=0x100.
REQ-029 Flush coincident with rvalid and a pop: count=2 -> count=0, the response is discarded, the state is IDLE, if_valid=0 the next cycle.
REQ-030 Misaligned pc_in=0x102 -> no imem_req; an entry {0x102, 0x0, err=1} appears; npc_enable pulses once.
REQ-031 Reset mid-WAIT: init_n low while WAIT with count=3 -> if_valid=0, imem_req=0 immediately; after release the first request issues no earlier than the second cycle.

Source files
------------

// File: rtl/ifetch_queue_pkg.sv
// Shared types for the instruction fetch queue: FSM encoding, queue entry layout
// and the instruction word used for misaligned-fetch placeholders.
package ifetch_queue_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DROP = 2'd2
   } ifq_state_t;

   localparam logic [31:0] NOP = 32'h0000_0000;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        err;
   } ifq_entry_t;

   localparam int ENTRY_W = $bits(ifq_entry_t);

endpackage

// File: rtl/ifq_fifo.sv
// DEPTH x 65-bit fetch queue storage; flush empties it and wins over push/pop.
module ifq_fifo
   import ifetch_queue_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     init_n,
   input  logic                     flush,
   input  logic                     push,
   input  logic                     pop,
   input  ifq_entry_t               wdata,
   output ifq_entry_t               head,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);

   ifq_entry_t     mem [DEPTH];
   logic [PW-1:0]  wr_ptr;
   logic [PW-1:0]  rd_ptr;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge init_n) begin
      if (!init_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push && !flush) mem[wr_ptr] <= wdata;
   end

   assign head = mem[rd_ptr];

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch front end: one outstanding imem request, slot reserved at
// issue, responses queued for decode; flush discards queued and in-flight work.
module ifetch_queue
   import ifetch_queue_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        init_n,
   input  logic [31:0] pc_in,
   output logic        npc_enable,
   input  logic        flush,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        if_valid,
   output logic [31:0] if_pc,
   output logic [31:0] if_instr,
   output logic        if_err,
   input  logic        id_ready
);

   localparam int CW = $clog2(DEPTH) + 1;

   ifq_state_t     state;
   ifq_state_t     state_nxt;
   logic           armed;
   logic [31:0]    tag;
   logic [CW-1:0]  count;
   logic           space;
   logic           aligned;
   logic           issue_ok;
   logic           push;
   logic           pop;
   ifq_entry_t     wdata;
   ifq_entry_t     head;

   // Only one request is ever in flight, so a free slot now is the reservation.
   assign space    = (count < CW'(DEPTH));
   assign aligned  = (pc_in[1:0] == 2'b00);
   assign issue_ok = (state == IDLE) && armed && !flush && space;

   // armed holds off issue for the first cycle after reset release.
   always_ff @(posedge clk or negedge init_n) begin
      if (!init_n) begin
         state <= IDLE;
         armed <= 1'b0;
         tag   <= '0;
      end else begin
         state <= state_nxt;
         armed <= 1'b1;
         if (imem_req && imem_gnt) tag <= pc_in;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (imem_req && imem_gnt) state_nxt = WAIT;
         WAIT: begin
            if (imem_rvalid)  state_nxt = IDLE;
            else if (flush)   state_nxt = DROP;
         end
         DROP: if (imem_rvalid) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      imem_req   = 1'b0;
      imem_addr  = '0;
      npc_enable = 1'b0;
      push       = 1'b0;
      wdata      = '0;
      case (state)
         IDLE: begin
            if (issue_ok) begin
               if (aligned) begin
                  imem_req   = 1'b1;
                  imem_addr  = pc_in;
                  npc_enable = imem_gnt;
               end else begin
                  push       = 1'b1;
                  npc_enable = 1'b1;
                  wdata      = '{pc: pc_in, instr: NOP, err: 1'b1};
               end
            end
         end
         WAIT: begin
            if (imem_rvalid && !flush) begin
               push  = 1'b1;
               wdata = '{pc: tag, instr: imem_rdata, err: 1'b0};
            end
         end
         default: ;
      endcase
   end

   assign if_valid = (count != '0);
   assign pop      = if_valid && id_ready;

   ifq_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk    (clk),
      .init_n (init_n),
      .flush  (flush),
      .push   (push),
      .pop    (pop),
      .wdata  (wdata),
      .head   (head),
      .count  (count)
   );

   assign if_pc    = if_valid ? head.pc    : '0;
   assign if_instr = if_valid ? head.instr : '0;
   assign if_err   = if_valid ? head.err   : 1'b0;

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue (DEPTH=4) with hand-computed expectations.
module tb_ifetch_queue;
   import ifetch_queue_pkg::*;

   logic        clk = 1'b0;
   logic        init_n;
   logic [31:0] pc_in;
   logic        npc_enable;
   logic        flush;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_instr;
   logic        if_err;
   logic        id_ready;

   int total = 0;
   int bad   = 0;

   ifetch_queue #(.DEPTH(4)) dut (
      .clk         (clk),
      .init_n      (init_n),
      .pc_in       (pc_in),
      .npc_enable  (npc_enable),
      .flush       (flush),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_gnt    (imem_gnt),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .if_valid    (if_valid),
      .if_pc       (if_pc),
      .if_instr    (if_instr),
      .if_err      (if_err),
      .id_ready    (id_ready)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Pure stimulus: one granted request followed by its response next cycle.
   task automatic fetch(input logic [31:0] pc, input logic [31:0] data);
      pc_in = pc; imem_gnt = 1'b1; imem_rvalid = 1'b0;
      tick();
      imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = data;
      tick();
      imem_rvalid = 1'b0;
   endtask

   task automatic test_reset;
      init_n = 1'b0; pc_in = '0; flush = 1'b0; imem_gnt = 1'b0;
      imem_rvalid = 1'b0; imem_rdata = '0; id_ready = 1'b0;
      #1;
      total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL rst_if_valid got=%0b exp=0", if_valid); end
      total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rst_imem_req got=%0b exp=0", imem_req); end
      total++; if (npc_enable !== 1'b0) begin bad++; $display("FAIL rst_npc got=%0b exp=0", npc_enable); end
      total++; if ({imem_addr, if_pc, if_instr, if_err} !== 97'h0) begin bad++; $display("FAIL rst_data addr=%0h pc=%0h instr=%0h err=%0b exp=0", imem_addr, if_pc, if_instr, if_err); end
      total++; if (dut.state !== IDLE) begin bad++; $display("FAIL rst_state got=%0d exp=%0d", dut.state, IDLE); end
      tick();
      tick();
      init_n = 1'b1;
      #1;
      total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rst_first_cycle_req got=%0b exp=0", imem_req); end
      tick();
      total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin bad++; $display("FAIL rst_second_cycle_req got=%0b/%0h exp=1/0", imem_req, imem_addr); end
   endtask

   task automatic test_seq;
      logic [31:0] pc;
      logic [31:0] data;
      id_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         pc = 32'(k * 4); data = 32'h1000 + 32'(k);
         pc_in = pc; imem_gnt = 1'b1; imem_rvalid = 1'b0;
         #1;
         total++; if (imem_req !== 1'b1 || imem_addr !== pc) begin bad++; $display("FAIL seq_req k=%0d got=%0b/%0h exp=1/%0h", k, imem_req, imem_addr, pc); end
         total++; if (npc_enable !== 1'b1) begin bad++; $display("FAIL seq_npc k=%0d got=%0b exp=1", k, npc_enable); end
         tick();
         imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = data; pc_in = pc + 32'd4;
         #1;
         total++; if (imem_req !== 1'b0 || npc_enable !== 1'b0 || if_valid !== 1'b0) begin bad++; $display("FAIL seq_wait k=%0d req=%0b npc=%0b valid=%0b exp=0/0/0", k, imem_req, npc_enable, if_valid); end
         tick();
         imem_rvalid = 1'b0;
         #1;
         total++; if (if_valid !== 1'b1 || if_pc !== pc || if_instr !== data || if_err !== 1'b0) begin bad++; $display("FAIL seq_out k=%0d got=%0b/%0h/%0h/%0b exp=1/%0h/%0h/0", k, if_valid, if_pc, if_instr, if_err, pc, data); end
         total++; if (npc_enable !== 1'b0) begin bad++; $display("FAIL seq_npc_idle k=%0d got=%0b exp=0", k, npc_enable); end
         tick();
      end
      #1;
      total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL seq_drained got=%0b exp=0", if_valid); end
   endtask

   task automatic test_backpressure;
      id_ready = 1'b0;
      for (int k = 0; k < 4; k++) fetch(32'h20 + 32'(4 * k), 32'h2000 + 32'(k));
      pc_in = 32'h30; imem_gnt = 1'b1;
      for (int c = 0; c < 3; c++) begin
         #1;
         total++; if (imem_req !== 1'b0 || npc_enable !== 1'b0) begin bad++; $display("FAIL bp_full c=%0d req=%0b npc=%0b exp=0/0", c, imem_req, npc_enable); end
         tick();
      end
      total++; if (dut.count !== 3'd4) begin bad++; $display("FAIL bp_count got=%0d exp=4", dut.count); end
      imem_gnt = 1'b0; id_ready = 1'b1;
      #1;
      total++; if (if_valid !== 1'b1 || if_pc !== 32'h20 || if_instr !== 32'h2000) begin bad++; $display("FAIL bp_head got=%0b/%0h/%0h exp=1/20/2000", if_valid, if_pc, if_instr); end
      total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL bp_pop_cycle_req got=%0b exp=0", imem_req); end
      tick();
      id_ready = 1'b0; imem_gnt = 1'b1;
      #1;
      total++; if (imem_req !== 1'b1 || imem_addr !== 32'h30 || npc_enable !== 1'b1) begin bad++; $display("FAIL bp_new_req got=%0b/%0h/%0b exp=1/30/1", imem_req, imem_addr, npc_enable); end
      tick();
      #1;
      total++; if (imem_req !== 1'b0 || npc_enable !== 1'b0) begin bad++; $display("FAIL bp_wait_req got=%0b/%0b exp=0/0", imem_req, npc_enable); end
      imem_rvalid = 1'b1; imem_rdata = 32'h3000;
      tick();
      imem_rvalid = 1'b0;
      #1;
      total++; if (imem_req !== 1'b0 || npc_enable !== 1'b0 || dut.count !== 3'd4) begin bad++; $display("FAIL bp_refull req=%0b npc=%0b count=%0d exp=0/0/4", imem_req, npc_enable, dut.count); end
      imem_gnt = 1'b0; flush = 1'b1;
      tick();
      flush = 1'b0;
      #1;
      total++; if (dut.count !== 3'd0 || if_valid !== 1'b0) begin bad++; $display("FAIL bp_flush count=%0d valid=%0b exp=0/0", dut.count, if_valid); end
   endtask

   task automatic test_flush_wait;
      id_ready = 1'b0; pc_in = 32'h40; imem_gnt = 1'b1;
      #1;
      total++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin bad++; $display("FAIL fw_req got=%0b/%0h exp=1/40", imem_req, imem_addr); end
      tick();
      imem_gnt = 1'b0; flush = 1'b1; pc_in = 32'h100;
      #1;
      total++; if (dut.state !== WAIT || imem_req !== 1'b0) begin bad++; $display("FAIL fw_wait state=%0d req=%0b exp=%0d/0", dut.state, imem_req, WAIT); end
      tick();
      flush = 1'b0;
      #1;
      total++; if (dut.state !== DROP || imem_req !== 1'b0) begin bad++; $display("FAIL fw_drop1 state=%0d req=%0b exp=%0d/0", dut.state, imem_req, DROP); end
      tick();
      imem_rvalid = 1'b1; imem_rdata = 32'hDEADBEEF;
      #1;
      total++; if (dut.state !== DROP || imem_req !== 1'b0) begin bad++; $display("FAIL fw_drop2 state=%0d req=%0b exp=%0d/0", dut.state, imem_req, DROP); end
      tick();
      imem_rvalid = 1'b0; imem_gnt = 1'b1;
      #1;
      total++; if (dut.state !== IDLE || if_valid !== 1'b0) begin bad++; $display("FAIL fw_idle state=%0d valid=%0b exp=%0d/0", dut.state, if_valid, IDLE); end
      total++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin bad++; $display("FAIL fw_next_req got=%0b/%0h exp=1/100", imem_req, imem_addr); end
      tick();
      imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h1111_1111;
      tick();
      imem_rvalid = 1'b0; id_ready = 1'b1;
      #1;
      total++; if (if_valid !== 1'b1 || if_pc !== 32'h100 || if_instr !== 32'h1111_1111) begin bad++; $display("FAIL fw_entry got=%0b/%0h/%0h exp=1/100/11111111", if_valid, if_pc, if_instr); end
      tick();
      id_ready = 1'b0;
   endtask

   task automatic test_flush_rvalid;
      id_ready = 1'b0;
      fetch(32'h200, 32'h2200);
      fetch(32'h204, 32'h2204);
      pc_in = 32'h208; imem_gnt = 1'b1;
      tick();
      imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hBAD0BAD0;
      flush = 1'b1; id_ready = 1'b1;
      #1;
      total++; if (dut.count !== 3'd2 || if_valid !== 1'b1 || imem_req !== 1'b0) begin bad++; $display("FAIL fr_pre count=%0d valid=%0b req=%0b exp=2/1/0", dut.count, if_valid, imem_req); end
      tick();
      flush = 1'b0; imem_rvalid = 1'b0; id_ready = 1'b0; pc_in = 32'h20C;
      #1;
      total++; if (dut.count !== 3'd0 || dut.state !== IDLE || if_valid !== 1'b0) begin bad++; $display("FAIL fr_post count=%0d state=%0d valid=%0b exp=0/%0d/0", dut.count, dut.state, if_valid, IDLE); end
      tick();
      total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL fr_discard valid=%0b exp=0", if_valid); end
   endtask

   task automatic test_misaligned;
      id_ready = 1'b0; pc_in = 32'h102; imem_gnt = 1'b1;
      #1;
      total++; if (imem_req !== 1'b0 || npc_enable !== 1'b1) begin bad++; $display("FAIL mis_issue req=%0b npc=%0b exp=0/1", imem_req, npc_enable); end
      tick();
      pc_in = 32'h104; imem_gnt = 1'b0; id_ready = 1'b1;
      #1;
      total++; if (if_valid !== 1'b1 || if_pc !== 32'h102 || if_instr !== NOP || if_err !== 1'b1) begin bad++; $display("FAIL mis_entry got=%0b/%0h/%0h/%0b exp=1/102/0/1", if_valid, if_pc, if_instr, if_err); end
      total++; if (npc_enable !== 1'b0 || dut.state !== IDLE) begin bad++; $display("FAIL mis_once npc=%0b state=%0d exp=0/%0d", npc_enable, dut.state, IDLE); end
      tick();
      id_ready = 1'b0;
      #1;
      total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL mis_pop valid=%0b exp=0", if_valid); end
   endtask

   task automatic test_reset_wait;
      id_ready = 1'b0;
      for (int k = 0; k < 3; k++) fetch(32'h300 + 32'(4 * k), 32'h3300 + 32'(k));
      pc_in = 32'h30C; imem_gnt = 1'b1;
      tick();
      imem_gnt = 1'b0;
      #1;
      total++; if (dut.state !== WAIT || dut.count !== 3'd3 || if_valid !== 1'b1) begin bad++; $display("FAIL rw_pre state=%0d count=%0d valid=%0b exp=%0d/3/1", dut.state, dut.count, if_valid, WAIT); end
      init_n = 1'b0;
      #1;
      total++; if (if_valid !== 1'b0 || imem_req !== 1'b0 || if_pc !== 32'h0) begin bad++; $display("FAIL rw_reset valid=%0b req=%0b pc=%0h exp=0/0/0", if_valid, imem_req, if_pc); end
      total++; if (dut.state !== IDLE || dut.count !== 3'd0) begin bad++; $display("FAIL rw_state state=%0d count=%0d exp=%0d/0", dut.state, dut.count, IDLE); end
      tick();
      init_n = 1'b1; pc_in = 32'h400; imem_gnt = 1'b1;
      #1;
      total++; if (imem_req !== 1'b0 || npc_enable !== 1'b0) begin bad++; $display("FAIL rw_first req=%0b npc=%0b exp=0/0", imem_req, npc_enable); end
      tick();
      total++; if (imem_req !== 1'b1 || imem_addr !== 32'h400) begin bad++; $display("FAIL rw_second req=%0b addr=%0h exp=1/400", imem_req, imem_addr); end
      imem_gnt = 1'b0;
   endtask

   initial begin
      test_reset();
      test_seq();
      test_backpressure();
      test_flush_wait();
      test_flush_rvalid();
      test_misaligned();
      test_reset_wait();
      tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
